// File: rtl/windowed_minmax_cmp.sv
// Streaming window min/max tracker: publishes min, max and their in-window indices
// with a one-cycle o_valid pulse after every WINDOW accepted samples.
module windowed_minmax_cmp #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned WINDOW = 16,
  localparam int unsigned IW    = $clog2(WINDOW)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  input  logic             CLR,
  output logic [WIDTH-1:0] MIN,
  output logic [WIDTH-1:0] MAX,
  output logic [IW-1:0]    MIN_IDX,
  output logic [IW-1:0]    MAX_IDX,
  output logic             O_VALID,
  output logic             BUSY
);

  localparam logic [IW:0] LAST = (IW+1)'(WINDOW - 1);
  localparam logic [IW:0] ONE  = (IW+1)'(1);

  // One extra bit keeps the subtraction exact, so extreme pairs never overflow.
  function automatic logic le(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] ae;
    logic [WIDTH:0] be;
    logic [WIDTH:0] diff;
    ae   = {SIGNED & a[WIDTH-1], a};
    be   = {SIGNED & b[WIDTH-1], b};
    diff = ae - be;
    return diff[WIDTH] | (diff == '0);
  endfunction

  logic [IW:0]      count_q;
  logic [WIDTH-1:0] rmin_q, rmax_q;
  logic [IW-1:0]    rmin_idx_q, rmax_idx_q;
  logic [WIDTH-1:0] min_q, max_q;
  logic [IW-1:0]    min_idx_q, max_idx_q;
  logic             o_valid_q, busy_q;

  logic             take_min, take_max;
  logic [WIDTH-1:0] min_d, max_d;
  logic [IW-1:0]    min_idx_d, max_idx_d;

  // Strict compares only, so ties keep the earlier index.
  always_comb begin
    take_min  = (count_q == '0) || !le(rmin_q, I);
    take_max  = (count_q == '0) || !le(I, rmax_q);
    min_d     = take_min ? I : rmin_q;
    max_d     = take_max ? I : rmax_q;
    min_idx_d = take_min ? count_q[IW-1:0] : rmin_idx_q;
    max_idx_d = take_max ? count_q[IW-1:0] : rmax_idx_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q    <= '0;
      rmin_q     <= '0;
      rmax_q     <= '0;
      rmin_idx_q <= '0;
      rmax_idx_q <= '0;
      min_q      <= '0;
      max_q      <= '0;
      min_idx_q  <= '0;
      max_idx_q  <= '0;
      o_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      if (CLR) begin
        count_q <= '0;
        busy_q  <= 1'b0;
      end else if (I_VALID) begin
        rmin_q     <= min_d;
        rmax_q     <= max_d;
        rmin_idx_q <= min_idx_d;
        rmax_idx_q <= max_idx_d;
        if (count_q == LAST) begin
          count_q   <= '0;
          busy_q    <= 1'b0;
          min_q     <= min_d;
          max_q     <= max_d;
          min_idx_q <= min_idx_d;
          max_idx_q <= max_idx_d;
          o_valid_q <= 1'b1;
        end else begin
          count_q <= count_q + ONE;
          busy_q  <= 1'b1;
        end
      end
    end
  end

  assign MIN     = min_q;
  assign MAX     = max_q;
  assign MIN_IDX = min_idx_q;
  assign MAX_IDX = max_idx_q;
  assign O_VALID = o_valid_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_windowed_minmax_cmp.sv
// Directed vector bench for windowed_minmax_cmp with signed and unsigned instances.
module tb_windowed_minmax_cmp;

  logic       clk = 1'b0;
  logic       rst, clr, vld;
  logic [7:0] din;

  logic [7:0] s_min, s_max, u_min, u_max;
  logic [1:0] s_mni, s_mxi, u_mni, u_mxi;
  logic       s_ov, s_busy, u_ov, u_busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  windowed_minmax_cmp #(.WIDTH(8), .SIGNED(1'b1), .WINDOW(4)) u_s (
    .CLK(clk), .RESET(rst), .I(din), .I_VALID(vld), .CLR(clr),
    .MIN(s_min), .MAX(s_max), .MIN_IDX(s_mni), .MAX_IDX(s_mxi), .O_VALID(s_ov), .BUSY(s_busy)
  );

  windowed_minmax_cmp #(.WIDTH(8), .SIGNED(1'b0), .WINDOW(4)) u_u (
    .CLK(clk), .RESET(rst), .I(din), .I_VALID(vld), .CLR(clr),
    .MIN(u_min), .MAX(u_max), .MIN_IDX(u_mni), .MAX_IDX(u_mxi), .O_VALID(u_ov), .BUSY(u_busy)
  );

  typedef struct {
    logic       rst, clr, vld;
    logic [7:0] d;
    logic [21:0] exp;  // {o_valid, busy, min, max, min_idx, max_idx}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [21:0] pk(input logic ov, input logic busy, input logic [7:0] mn,
                                     input logic [7:0] mx, input logic [1:0] mni,
                                     input logic [1:0] mxi);
    return {ov, busy, mn, mx, mni, mxi};
  endfunction

  task automatic add(input logic r, input logic c, input logic v, input logic [7:0] d,
                     input logic ov, input logic busy, input logic [7:0] mn, input logic [7:0] mx,
                     input logic [1:0] mni, input logic [1:0] mxi);
    vec_t t;
    t.rst = r; t.clr = c; t.vld = v; t.d = d;
    t.exp = pk(ov, busy, mn, mx, mni, mxi);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got {ov,busy,min,max,mni,mxi}=%h required %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step(input logic r, input logic c, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst = r; clr = c; vld = v; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; vld = 1'b0; din = 8'h00;

    add(1,0,0,8'h00, 0,0,8'h00,8'h00,0,0);
    // signed compare with extreme pair
    add(0,0,1,8'h05, 0,1,8'h00,8'h00,0,0);
    add(0,0,1,8'h80, 0,1,8'h00,8'h00,0,0);
    add(0,0,1,8'h7F, 0,1,8'h00,8'h00,0,0);
    add(0,0,1,8'hFF, 1,0,8'h80,8'h7F,1,2);
    add(0,0,0,8'h00, 0,0,8'h80,8'h7F,1,2);
    // ties keep earliest index
    add(0,0,1,8'h03, 0,1,8'h80,8'h7F,1,2);
    add(0,0,1,8'h03, 0,1,8'h80,8'h7F,1,2);
    add(0,0,1,8'h03, 0,1,8'h80,8'h7F,1,2);
    add(0,0,1,8'h03, 1,0,8'h03,8'h03,0,0);
    add(0,0,1,8'h10, 0,1,8'h03,8'h03,0,0);
    add(0,0,1,8'h02, 0,1,8'h03,8'h03,0,0);
    add(0,0,1,8'h02, 0,1,8'h03,8'h03,0,0);
    add(0,0,1,8'h10, 1,0,8'h02,8'h10,1,0);
    // gapped stream 1..8
    add(0,0,1,8'h01, 0,1,8'h02,8'h10,1,0);
    add(0,0,0,8'h00, 0,1,8'h02,8'h10,1,0);
    add(0,0,1,8'h02, 0,1,8'h02,8'h10,1,0);
    add(0,0,0,8'h00, 0,1,8'h02,8'h10,1,0);
    add(0,0,1,8'h03, 0,1,8'h02,8'h10,1,0);
    add(0,0,0,8'h00, 0,1,8'h02,8'h10,1,0);
    add(0,0,1,8'h04, 1,0,8'h01,8'h04,0,3);
    add(0,0,0,8'h00, 0,0,8'h01,8'h04,0,3);
    add(0,0,1,8'h05, 0,1,8'h01,8'h04,0,3);
    add(0,0,0,8'h00, 0,1,8'h01,8'h04,0,3);
    add(0,0,1,8'h06, 0,1,8'h01,8'h04,0,3);
    add(0,0,0,8'h00, 0,1,8'h01,8'h04,0,3);
    add(0,0,1,8'h07, 0,1,8'h01,8'h04,0,3);
    add(0,0,0,8'h00, 0,1,8'h01,8'h04,0,3);
    add(0,0,1,8'h08, 1,0,8'h05,8'h08,0,3);
    add(0,0,0,8'h00, 0,0,8'h05,8'h08,0,3);
    // continuous back-to-back windows
    add(0,0,1,8'h09, 0,1,8'h05,8'h08,0,3);
    add(0,0,1,8'h0A, 0,1,8'h05,8'h08,0,3);
    add(0,0,1,8'h0B, 0,1,8'h05,8'h08,0,3);
    add(0,0,1,8'h0C, 1,0,8'h09,8'h0C,0,3);
    add(0,0,1,8'h0D, 0,1,8'h09,8'h0C,0,3);
    add(0,0,1,8'h0E, 0,1,8'h09,8'h0C,0,3);
    add(0,0,1,8'h0F, 0,1,8'h09,8'h0C,0,3);
    add(0,0,1,8'h10, 1,0,8'h0D,8'h10,0,3);
    add(0,0,0,8'h00, 0,0,8'h0D,8'h10,0,3);
    // clear mid-window drops the concurrent sample
    add(0,0,1,8'h01, 0,1,8'h0D,8'h10,0,3);
    add(0,0,1,8'h7E, 0,1,8'h0D,8'h10,0,3);
    add(0,1,1,8'h50, 0,0,8'h0D,8'h10,0,3);
    add(0,0,1,8'h10, 0,1,8'h0D,8'h10,0,3);
    add(0,0,1,8'h20, 0,1,8'h0D,8'h10,0,3);
    add(0,0,1,8'h30, 0,1,8'h0D,8'h10,0,3);
    add(0,0,1,8'h40, 1,0,8'h10,8'h40,0,3);
    // clear on the final-sample edge publishes nothing
    add(0,0,1,8'h60, 0,1,8'h10,8'h40,0,3);
    add(0,0,1,8'h61, 0,1,8'h10,8'h40,0,3);
    add(0,0,1,8'h62, 0,1,8'h10,8'h40,0,3);
    add(0,1,1,8'h63, 0,0,8'h10,8'h40,0,3);
    add(0,0,0,8'h00, 0,0,8'h10,8'h40,0,3);
    // reset mid-window, then a fresh window
    add(0,0,1,8'h11, 0,1,8'h10,8'h40,0,3);
    add(0,0,1,8'h22, 0,1,8'h10,8'h40,0,3);
    add(0,0,1,8'h33, 0,1,8'h10,8'h40,0,3);
    add(1,0,0,8'h00, 0,0,8'h00,8'h00,0,0);
    add(0,0,1,8'h44, 0,1,8'h00,8'h00,0,0);
    add(0,0,1,8'h05, 0,1,8'h00,8'h00,0,0);
    add(0,0,1,8'h70, 0,1,8'h00,8'h00,0,0);
    add(0,0,1,8'h06, 1,0,8'h05,8'h70,1,2);
    add(0,0,0,8'h00, 0,0,8'h05,8'h70,1,2);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst, vecs[k].clr, vecs[k].vld, vecs[k].d);
      check($sformatf("vec%0d", k), pk(s_ov, s_busy, s_min, s_max, s_mni, s_mxi), vecs[k].exp);
    end

    // unsigned vs signed on the same stream
    step(1,0,0,8'h00);
    check("rst_u", pk(u_ov, u_busy, u_min, u_max, u_mni, u_mxi), pk(0,0,8'h00,8'h00,0,0));
    step(0,0,1,8'h05);
    step(0,0,1,8'h80);
    step(0,0,1,8'h7F);
    step(0,0,1,8'hFF);
    check("uns_t1", pk(u_ov, u_busy, u_min, u_max, u_mni, u_mxi), pk(1,0,8'h05,8'hFF,0,3));
    check("sgn_t1", pk(s_ov, s_busy, s_min, s_max, s_mni, s_mxi), pk(1,0,8'h80,8'h7F,1,2));
    step(0,0,0,8'h00);
    check("uns_hold", pk(u_ov, u_busy, u_min, u_max, u_mni, u_mxi), pk(0,0,8'h05,8'hFF,0,3));
    step(0,0,1,8'h00);
    step(0,0,1,8'hFF);
    step(0,0,1,8'h80);
    step(0,0,1,8'h7F);
    check("uns_ext", pk(u_ov, u_busy, u_min, u_max, u_mni, u_mxi), pk(1,0,8'h00,8'hFF,0,1));
    check("sgn_ext", pk(s_ov, s_busy, s_min, s_max, s_mni, s_mxi), pk(1,0,8'h80,8'h7F,2,3));
    step(0,0,0,8'h00);
    check("sgn_hold", pk(s_ov, s_busy, s_min, s_max, s_mni, s_mxi), pk(0,0,8'h80,8'h7F,2,3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/windowed_minmax_cmp.md
Name: windowed_minmax_cmp

Overview:
- Streaming comparator block: accepts WIDTH-bit samples under a valid strobe and tracks running minimum and maximum over fixed windows of WINDOW samples.
- Compare mode is signed (two's complement) or unsigned, fixed by parameter.
- Comparisons are subtract-based less-or-equal, the same style as the existing combinational SLE/ULE comparators.
- At the end of each window it publishes MIN/MAX values and their sample indices with a one-cycle O_VALID pulse.
- Sits after sensor/ADC capture paths for peak detection.

Parameters:
- WIDTH, 8, sample width in bits (>= 2).
- SIGNED, 1, 1 = two's-complement compare; 0 = unsigned compare.
- WINDOW, 16, samples per window (>= 2); IW = clog2(WINDOW) is the index width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- I  input  WIDTH  sample data.
- I_VALID  input  1  sample is accepted on any rising edge where I_VALID=1 and CLR=0.
- CLR  input  1  synchronous abort of the in-progress window.
- MIN  output  WIDTH  minimum of the last completed window.
- MAX  output  WIDTH  maximum of the last completed window.
- MIN_IDX  output  IW  in-window index (0-based) of MIN.
- MAX_IDX  output  IW  in-window index of MAX.
- O_VALID  output  1  one-cycle pulse: a new result is on MIN/MAX/idx.
- BUSY  output  1  high while a window is partially filled (count != 0).

Behaviour:
- Reset (RESET=1 at edge), highest priority:
  - count, running min/max, running indices, MIN, MAX, MIN_IDX, MAX_IDX all go to 0.
  - O_VALID=0, BUSY=0.
  - Reset mid-window discards all partial state; no O_VALID is produced for that window.
- State: count (IW+1 bits) cycles 0..WINDOW-1. Running registers rmin, rmax, rmin_idx, rmax_idx are distinct from the output registers.
- Compare: a <= b is evaluated in the selected mode.
  - SIGNED=1: two's-complement order, so 0x80 < 0x7F for WIDTH=8.
  - SIGNED=0: plain magnitude order.
- Accepted sample at count=0: rmin=rmax=I, both indices=0, count=1.
- Accepted sample at 0 < count < WINDOW-1:
  - If I < rmin (strictly), load rmin=I and rmin_idx=count.
  - If rmax < I (strictly), load rmax=I and rmax_idx=count.
  - count increments.
- Ties keep the earliest index.
- Accepted sample at count=WINDOW-1 (final sample):
  - MIN/MAX/MIN_IDX/MAX_IDX load the final values, including this sample, at this same edge.
  - O_VALID=1 for exactly the following cycle.
  - count returns to 0.
- Latency: result and O_VALID are visible 1 cycle after the edge accepting the final sample.
- Back-to-back windows are supported. A sample accepted in the cycle where O_VALID=1 is index 0 of the next window.
- Outputs MIN/MAX/idx hold between windows and change only at window completion or reset.
- O_VALID is 0 in every cycle other than the one described above.
- I_VALID=0 cycles (gaps): no state change; count is held.
- CLR=1 (and RESET=0):
  - count goes to 0 and running registers are don't-care.
  - Output registers and O_VALID=0 are unaffected; the last published result is retained.
  - CLR with I_VALID in the same cycle: CLR wins and the sample is dropped.
  - CLR on the final-sample edge: no result is published.
- BUSY = (count != 0), registered.
- No overflow is possible. Compare logic must handle the extreme pair (most-negative vs most-positive) correctly in both modes.

Test Plan:
1. WIDTH=8, SIGNED=1, WINDOW=4; samples 0x05, 0x80, 0x7F, 0xFF on consecutive cycles -> one cycle after the 4th edge: O_VALID=1, MIN=0x80, MIN_IDX=1, MAX=0x7F, MAX_IDX=2; next cycle O_VALID=0 and outputs hold.
2. Same stimulus with SIGNED=0 -> MIN=0x05, MIN_IDX=0, MAX=0xFF, MAX_IDX=3.
3. Ties with SIGNED=1, WINDOW=4: samples 0x03, 0x03, 0x03, 0x03 -> MIN=MAX=0x03, MIN_IDX=MAX_IDX=0. Samples 0x10, 0x02, 0x02, 0x10 -> MIN_IDX=1, MAX_IDX=0.
4. Gaps and back-to-back windows: 8 samples 1..8 with I_VALID toggling 1,0,1,0,... -> O_VALID pulses twice, carrying (MIN=1, MAX=4) then (MIN=5, MAX=8). A continuous stream gives a pulse every 4 accepted samples, with no sample lost.
5. CLR after 2 samples (0x01, 0x7E), with I_VALID=1 and I=0x50 on the CLR cycle, then 4 samples 0x10, 0x20, 0x30, 0x40:
   - No pulse for the aborted window; 0x50 is dropped.
   - One pulse with MIN=0x10, MAX=0x40.
   - The previously published result stays visible until that pulse.
6. RESET asserted for 1 cycle after 3 samples of a window -> all outputs 0, BUSY=0, no O_VALID. The next 4 samples produce a correct fresh result.
